// File: rtl/axil_arb_pkg.sv
// Shared types and helpers for the AXI4-Lite request arbiter.
package axil_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Binary requester index to one-hot grant vector.
    function automatic logic [NUM_REQ-1:0] onehot4(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        case (idx)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/axil_prio_enc4.sv
// Fixed-priority 4-to-2 encoder (bit 3 wins) with an any-request qualifier.
module axil_prio_enc4
    import axil_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_vec,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Highest set bit wins; the index is only meaningful while any is high.
    always_comb begin
        idx = 2'd0;
        if (req_vec[3]) begin
            idx = 2'd3;
        end else if (req_vec[2]) begin
            idx = 2'd2;
        end else if (req_vec[1]) begin
            idx = 2'd1;
        end else begin
            idx = 2'd0;
        end
    end

    assign any = |req_vec;

endmodule

// File: rtl/axil_req_arbiter.sv
// Single-transaction AXI4-Lite grant arbiter with response/timeout release
// and a consecutive-win limit against starvation.
module axil_req_arbiter
    import axil_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 256,
    parameter int MAX_CONSEC  = 4,
    parameter int CNT_W       = 9
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_write,
    input  logic               bvalid,
    input  logic               bready,
    input  logic               rvalid,
    input  logic               rready,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_write,
    output logic               timeout_err,
    output logic [IDX_W-1:0]   timeout_idx
);

    localparam bit             TMO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYC - 1) : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    // consec saturates at 7, so a limit above 7 can never trigger.
    localparam bit             MASK_EN  = (MAX_CONSEC != 0) && (MAX_CONSEC <= 7);
    localparam logic [2:0]     MAXC_L   = MASK_EN ? 3'(MAX_CONSEC) : 3'd7;

    arb_state_e         state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [IDX_W-1:0]   last_idx_r;
    logic [2:0]         consec_r;

    logic [NUM_REQ-1:0] mask_s;
    logic [NUM_REQ-1:0] eff_req_s;
    logic [IDX_W-1:0]   enc_idx_s;
    logic               enc_any_s;
    logic               done_s;
    logic               tmo_hit_s;

    // Mask the repeat winner only while someone else is actually waiting.
    always_comb begin
        mask_s = 4'b0000;
        if (MASK_EN && (consec_r >= MAXC_L) &&
            ((req & ~onehot4(last_idx_r)) != 4'b0000)) begin
            mask_s = onehot4(last_idx_r);
        end else begin
            mask_s = 4'b0000;
        end
    end

    assign eff_req_s = req & ~mask_s;

    axil_prio_enc4 u_enc (
        .req_vec (eff_req_s),
        .idx     (enc_idx_s),
        .any     (enc_any_s)
    );

    // Completion is taken only from the channel matching the latched direction.
    always_comb begin
        done_s = 1'b0;
        if (gnt_write) begin
            done_s = bvalid & bready;
        end else begin
            done_s = rvalid & rready;
        end
    end

    assign tmo_hit_s = TMO_EN && (cnt_r == TMO_LAST);

    // Arbitration FSM, timeout counter and starvation tracking.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_r     <= IDLE;
            gnt         <= 4'b0000;
            gnt_valid   <= 1'b0;
            gnt_idx     <= 2'd0;
            gnt_write   <= 1'b0;
            timeout_err <= 1'b0;
            timeout_idx <= 2'd0;
            cnt_r       <= {CNT_W{1'b0}};
            last_idx_r  <= 2'd0;
            consec_r    <= 3'd0;
        end else begin
            timeout_err <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (enc_any_s) begin
                        state_r   <= BUSY;
                        gnt       <= onehot4(enc_idx_s);
                        gnt_valid <= 1'b1;
                        gnt_idx   <= enc_idx_s;
                        gnt_write <= req_write[enc_idx_s];
                        cnt_r     <= {CNT_W{1'b0}};
                        if (enc_idx_s == last_idx_r) begin
                            if (consec_r != 3'd7) begin
                                consec_r <= consec_r + 3'd1;
                            end
                        end else begin
                            consec_r   <= 3'd1;
                            last_idx_r <= enc_idx_s;
                        end
                    end
                end
                BUSY: begin
                    if (done_s) begin
                        state_r   <= IDLE;
                        gnt       <= 4'b0000;
                        gnt_valid <= 1'b0;
                    end else if (tmo_hit_s) begin
                        state_r     <= IDLE;
                        gnt         <= 4'b0000;
                        gnt_valid   <= 1'b0;
                        timeout_err <= 1'b1;
                        timeout_idx <= gnt_idx;
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    gnt       <= 4'b0000;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_req_arbiter.sv
// Scoreboard bench for axil_req_arbiter: expected grants are queued as
// stimulus is driven and checked when a new grant appears.
module tb_axil_req_arbiter;

    logic       ACLK = 1'b0;
    logic       ARESET;
    logic [3:0] req;
    logic [3:0] req_write;
    logic       bvalid, bready, rvalid, rready;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_idx;
    logic       gnt_write;
    logic       timeout_err;
    logic [1:0] timeout_idx;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] idx;
        logic       wr;
    } exp_t;

    exp_t exp_q[$];
    logic gv_prev = 1'b0;

    axil_req_arbiter #(
        .TIMEOUT_CYC (8),
        .MAX_CONSEC  (4),
        .CNT_W       (4)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .req         (req),
        .req_write   (req_write),
        .bvalid      (bvalid),
        .bready      (bready),
        .rvalid      (rvalid),
        .rready      (rready),
        .gnt         (gnt),
        .gnt_valid   (gnt_valid),
        .gnt_idx     (gnt_idx),
        .gnt_write   (gnt_write),
        .timeout_err (timeout_err),
        .timeout_idx (timeout_idx)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic expect_grant(input logic [1:0] idx, input logic wr);
        exp_t e;
        e.idx = idx;
        e.wr  = wr;
        exp_q.push_back(e);
    endtask

    // Read completion: one-cycle handshake pulse.
    task automatic read_done();
        rvalid = 1'b1; rready = 1'b1;
        tick();
        rvalid = 1'b0; rready = 1'b0;
    endtask

    // Scoreboard: every rising edge of gnt_valid consumes one expected grant.
    always @(negedge ACLK) begin
        if (gnt_valid && !gv_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexp_gnt", 32'(gnt), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_idx", 32'(gnt_idx), 32'(e.idx));
                chk("sb_onehot", 32'(gnt), 32'(4'b0001 << e.idx));
                chk("sb_write", 32'(gnt_write), 32'(e.wr));
            end
        end
        gv_prev = gnt_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] seq_exp [10];
        seq_exp = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};

        ARESET = 1'b1; req = 4'b0000; req_write = 4'b0000;
        bvalid = 1'b0; bready = 1'b0; rvalid = 1'b0; rready = 1'b0;
        repeat (3) tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_gv", 32'(gnt_valid), 32'd0);
        chk("rst_idx", 32'(gnt_idx), 32'd0);
        chk("rst_wr", 32'(gnt_write), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        chk("rst_tidx", 32'(timeout_idx), 32'd0);
        ARESET = 1'b0;
        tick();

        // Priority pick, read completion, back-to-back grant after idle gap
        req = 4'b0101;
        expect_grant(2'd2, 1'b0);
        tick();
        chk("lat_gnt", 32'(gnt), 32'(4'b0100));
        tick();
        chk("hold_gnt", 32'(gnt), 32'(4'b0100));
        read_done();
        chk("rel_gnt", 32'(gnt), 32'd0);
        expect_grant(2'd2, 1'b0);
        tick();
        chk("regrant", 32'(gnt), 32'(4'b0100));
        req = 4'b0000;
        read_done();
        tick();

        // Write grant ignores read handshake, released by write response
        req = 4'b1000; req_write = 4'b1000;
        expect_grant(2'd3, 1'b1);
        tick();
        read_done();
        chk("wr_ignore_r", 32'(gnt), 32'(4'b1000));
        tick();
        bvalid = 1'b1; bready = 1'b1; req = 4'b0000;
        tick();
        chk("wr_release", 32'(gnt), 32'd0);
        bvalid = 1'b0; bready = 1'b0; req_write = 4'b0000;
        tick();

        // Timeout release after exactly 8 busy cycles
        req = 4'b0010;
        expect_grant(2'd1, 1'b0);
        tick();
        req = 4'b0000;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("tmo_hold", 32'(gnt), 32'(4'b0010));
            chk("tmo_nopulse", 32'(timeout_err), 32'd0);
        end
        tick();
        chk("tmo_rel", 32'(gnt), 32'd0);
        chk("tmo_pulse", 32'(timeout_err), 32'd1);
        chk("tmo_idx", 32'(timeout_idx), 32'd1);
        tick();
        chk("tmo_once", 32'(timeout_err), 32'd0);
        chk("tmo_idx_hold", 32'(timeout_idx), 32'd1);

        // Completion in the would-be timeout cycle: no error pulse
        req = 4'b0010;
        expect_grant(2'd1, 1'b0);
        tick();
        req = 4'b0000;
        repeat (7) tick();
        read_done();
        chk("late_done_rel", 32'(gnt), 32'd0);
        chk("late_done_nopulse", 32'(timeout_err), 32'd0);
        tick();

        // Starvation guard with two competing requesters
        req = 4'b1001;
        for (int i = 0; i < 10; i++) begin
            expect_grant(seq_exp[i], 1'b0);
            tick();
            read_done();
        end
        // Lone requester is never masked
        req = 4'b1000;
        for (int i = 0; i < 6; i++) begin
            expect_grant(2'd3, 1'b0);
            tick();
            read_done();
        end
        req = 4'b0000;
        tick();

        // Reset in the middle of a transaction
        req = 4'b0100;
        expect_grant(2'd2, 1'b0);
        tick();
        ARESET = 1'b1;
        tick();
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_gv", 32'(gnt_valid), 32'd0);
        chk("mid_rst_idx", 32'(gnt_idx), 32'd0);
        chk("mid_rst_tidx", 32'(timeout_idx), 32'd0);
        ARESET = 1'b0;
        expect_grant(2'd2, 1'b0);
        tick();
        chk("post_rst_gnt", 32'(gnt), 32'(4'b0100));
        req = 4'b0000;
        read_done();
        tick();

        // Dropping req during BUSY does not release the grant
        req = 4'b0001;
        expect_grant(2'd0, 1'b0);
        tick();
        req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("drop_hold", 32'(gnt), 32'(4'b0001));
        end
        read_done();
        chk("drop_rel", 32'(gnt), 32'd0);
        repeat (3) tick();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axil_req_arbiter.md
# axil_req_arbiter

Sequential 4-requester grant arbiter for the AXI4-Lite interconnect. It sits directly downstream of the 4-to-2 priority encode and consumes its 2-bit winner index. It latches the winner, holds a one-hot grant for exactly one AXI4-Lite transaction, and releases the grant on the matching response handshake or on timeout. A consecutive-win limit keeps a high-priority requester from starving the others.

## Interface
- `TIMEOUT_CYC`, default 256: maximum BUSY cycles before forced release. 0 disables the timeout.
- `MAX_CONSEC`, default 4: maximum back-to-back grants to one requester while others wait. 0 disables the limit.
- `CNT_W`, default 9: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYC.
- `ACLK` input 1: the single clock. All logic is on the rising edge.
- `ARESET` input 1: synchronous, active-high reset.
- `req` input 4: request lines. Bit 3 has the highest priority.
- `req_write` input 4: per requester, 1 means write transaction, 0 means read.
- `bvalid`, `bready` input 1 each: write-response handshake on the granted path.
- `rvalid`, `rready` input 1 each: read-data handshake on the granted path.
- `gnt` output 4: one-hot grant, registered.
- `gnt_valid` output 1: grant active, equal to the OR of `gnt`.
- `gnt_idx` output 2: binary index of the granted requester.
- `gnt_write` output 1: latched `req_write` of the winner.
- `timeout_err` output 1: one-cycle pulse on forced release.
- `timeout_idx` output 2: index released by timeout. Holds until the next timeout.

## Operation
- States: IDLE and BUSY.
- **IDLE**
  - Compute `eff_req` = `req` with the starvation-mask bit cleared.
  - If `eff_req` is nonzero, latch `gnt_idx` = priority encode of `eff_req` (3 > 2 > 1 > 0), `gnt` = one-hot of that index, `gnt_write` = `req_write[idx]`, clear the timeout counter, and go to BUSY.
  - The encode is never evaluated on an all-zero vector. The "any request" qualifier gates it.
- **BUSY**
  - Grant is held regardless of `req`; dropping `req` has no effect.
  - Completion is `bvalid&bready` when `gnt_write` = 1, else `rvalid&rready`. A handshake on the other channel is ignored.
  - On completion: clear `gnt`, go to IDLE.
  - Otherwise, if `TIMEOUT_CYC` != 0 and counter == `TIMEOUT_CYC`-1: clear `gnt`, pulse `timeout_err`, set `timeout_idx` = `gnt_idx`, go to IDLE.
  - Otherwise increment the counter, saturating.
  - Completion and timeout in the same cycle: completion wins and there is no error pulse.
- **Starvation guard**
  - `last_idx` (2 bits) and `consec` (3 bits) update at each grant. If the new index equals `last_idx`, `consec` increments, saturating at 7; otherwise `consec` = 1 and `last_idx` = the new index.
  - Mask bit `last_idx` applies in IDLE only when `MAX_CONSEC` != 0, `consec` >= `MAX_CONSEC`, and `req` has another bit set. With a lone requester it is never masked.
- **Reset**
  - `ARESET` dominates every state, including mid-BUSY: state = IDLE, `gnt` = 0, `gnt_valid` = 0, `gnt_idx` = 0, `gnt_write` = 0, `timeout_err` = 0, `timeout_idx` = 0, counters = 0, `last_idx` = 0, `consec` = 0.
  - An outstanding transaction is abandoned silently.

## Timing
- Request seen at edge N in IDLE -> `gnt` valid after edge N. Arbitration latency is 1 cycle.
- Completion handshake sampled at edge M -> `gnt` = 0 after edge M. The earliest next grant is after edge M+1, so there is a mandatory 1-cycle idle gap between grants.
- Timeout: a grant made at edge G releases after edge G+`TIMEOUT_CYC`, with `timeout_err` high for that one cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `axil_arb_pkg`:
  - state enum (IDLE, BUSY)
  - `NUM_REQ` = 4
  - `IDX_W` = 2
  - function `onehot4(idx)`
- Sub-module `axil_prio_enc4`: combinational 4-to-2 priority encode with an `any` output. It is instantiated once on `eff_req`.
- Top level contains the FSM, timeout counter and starvation registers.

## Test plan
- Reset, then `req` = 4'b0101 -> after 1 cycle `gnt` = 4'b0100, `gnt_idx` = 2. On `rvalid&rready` (read), `gnt` = 0, then the next grant comes 1 cycle later.
- `req` = 4'b1000 with `req_write[3]` = 1, `rvalid&rready` pulsed -> grant held. A later `bvalid&bready` -> release.
- `TIMEOUT_CYC` = 8, grant idx 1, no response -> release after 8 cycles, `timeout_err` pulses once, `timeout_idx` = 1. Also check completion in the final cycle -> no pulse.
- `req` held at 4'b1001, `MAX_CONSEC` = 4, every transaction completed -> sequence 3,3,3,3,0,3,3,3,3,0. `req` = 4'b1000 alone -> always 3.
- `ARESET` asserted mid-BUSY -> all outputs 0 the next cycle. With `req` still present after reset is released, a grant comes 1 cycle later.
- `req` dropped to 0 during BUSY -> `gnt` held until the completion handshake.
